// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - 4-digit multiplexed 7-segment driver for an mm:ss stopwatch.
// Frame-latched digits, anti-ghost guard at each slot start, field blink in adjust mode.
module seg_scan_driver #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000,
    parameter int GUARD_CYC = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] min1,
    input  logic [3:0] min0,
    input  logic [3:0] sec1,
    input  logic [3:0] sec0,
    input  logic       adjust,
    input  logic       select,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0]  GUARD_END  = SCAN_W'(GUARD_CYC);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [SCAN_W-1:0]  scan_cnt_q,  scan_cnt_d;
    logic [1:0]         idx_q,       idx_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_ph_q,  blink_ph_d;
    logic [15:0]        shadow_q,    shadow_d;
    logic [3:0]         an_q,        an_d;
    logic [6:0]         seg_q,       seg_d;
    logic               dp_q,        dp_d;

    logic       scan_wrap;
    logic       in_guard;
    logic       in_field;
    logic       blank;
    logic [3:0] nibble;

    always_comb begin
        scan_wrap  = (scan_cnt_q == SCAN_LAST);
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
        idx_d      = scan_wrap ? idx_q + 2'd1 : idx_q;

        // Only the shadow copy is displayed, so a whole frame always shows one time value.
        shadow_d = shadow_q;
        if (scan_wrap && (idx_q == 2'd3)) begin
            shadow_d = {min1, min0, sec1, sec0};
        end

        // Leaving adjust clears the phase so the next entry starts visible.
        blink_cnt_d = '0;
        blink_ph_d  = 1'b0;
        if (adjust) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                blink_ph_d  = blink_ph_q;
            end
        end
    end

    always_comb begin
        case (idx_q)
            2'd0:    nibble = shadow_q[3:0];
            2'd1:    nibble = shadow_q[7:4];
            2'd2:    nibble = shadow_q[11:8];
            default: nibble = shadow_q[15:12];
        endcase

        in_guard = (scan_cnt_q < GUARD_END);
        in_field = select ? ~idx_q[1] : idx_q[1];
        blank    = adjust & blink_ph_q & in_field;

        an_d = 4'hF;
        if (!in_guard && !blank) begin
            an_d[idx_q] = 1'b0;
        end

        case (nibble)
            4'd0:    seg_d = 7'h40;
            4'd1:    seg_d = 7'h79;
            4'd2:    seg_d = 7'h24;
            4'd3:    seg_d = 7'h30;
            4'd4:    seg_d = 7'h19;
            4'd5:    seg_d = 7'h12;
            4'd6:    seg_d = 7'h02;
            4'd7:    seg_d = 7'h78;
            4'd8:    seg_d = 7'h00;
            4'd9:    seg_d = 7'h10;
            default: seg_d = 7'h3F;
        endcase
        if (blank) begin
            seg_d = 7'h7F;
        end

        dp_d = ~((idx_q == 2'd2) && !in_guard && !blank);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt_q  <= '0;
            idx_q       <= 2'd0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            shadow_q    <= 16'h0000;
            an_q        <= 4'hF;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            shadow_q    <= shadow_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - directed self-checking bench for seg_scan_driver.
module tb_seg_scan_driver;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] min1, min0, sec1, sec0;
    logic       adjust, select;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_checks = 0;
    int n_errors = 0;

    seg_scan_driver #(
        .SCAN_DIV  (8),
        .BLINK_DIV (64),
        .GUARD_CYC (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .min1    (min1),
        .min0    (min0),
        .sec1    (sec1),
        .sec0    (sec0),
        .adjust  (adjust),
        .select  (select),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_digits(input logic [15:0] v);
        {min1, min0, sec1, sec0} = v;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".an"},  8'(an),  8'h0F);
        check({tag, ".seg"}, 8'(seg), 8'h7F);
        check({tag, ".dp"},  8'(dp),  8'h01);
    endtask

    // One 8-cycle slot: 2 guard cycles with anodes off, then 6 cycles of the digit.
    task automatic check_slot(input string tag, input int idx, input logic [6:0] e_seg, input bit blanked);
        logic [3:0] e_an;
        logic [6:0] e_sg;
        logic       e_dp;
        e_an = 4'hF;
        if (!blanked) e_an[idx] = 1'b0;
        e_sg = blanked ? 7'h7F : e_seg;
        e_dp = (idx == 2 && !blanked) ? 1'b0 : 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c < 2) begin
                check($sformatf("%s.c%0d.an_guard", tag, c), 8'(an), 8'h0F);
            end else begin
                check($sformatf("%s.c%0d.an",  tag, c), 8'(an),  8'(e_an));
                check($sformatf("%s.c%0d.seg", tag, c), 8'(seg), 8'(e_sg));
                check($sformatf("%s.c%0d.dp",  tag, c), 8'(dp),  8'(e_dp));
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] blank);
        for (int i = 0; i < 4; i++) begin
            check_slot($sformatf("%s.s%0d", tag, i), i, segs[i*7 +: 7], blank[i]);
        end
    endtask

    localparam logic [27:0] ZEROS = {4{7'h40}};
    localparam logic [27:0] C236  = {7'h3F, 7'h24, 7'h30, 7'h02};

    initial begin
        reset_n = 1'b0;
        adjust  = 1'b0;
        select  = 1'b0;
        set_digits(16'h0000);

        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            set_digits(16'($urandom));
            adjust = 1'($urandom);
            select = 1'($urandom);
            @(negedge clk);
            check_reset_outputs($sformatf("reset%0d", k));
        end

        @(negedge clk);
        set_digits(16'h1234);
        adjust  = 1'b0;
        select  = 1'b0;
        reset_n = 1'b1;

        check_frame("scan_f0", ZEROS, 4'b0000);
        check_slot("scan_f1.s0", 0, 7'h19, 1'b0);
        check_slot("scan_f1.s1", 1, 7'h30, 1'b0);
        check_slot("scan_f1.s2", 2, 7'h24, 1'b0);
        set_digits(16'hC235);
        check_slot("tear_f1.s3", 3, 7'h79, 1'b0);
        check_slot("tear_f2.s0", 0, 7'h12, 1'b0);
        sec0 = 4'd6;
        check_slot("tear_f2.s1", 1, 7'h30, 1'b0);
        check_slot("tear_f2.s2", 2, 7'h24, 1'b0);
        check_slot("bcd_f2.s3",  3, 7'h3F, 1'b0);
        check_slot("tear_f3.s0", 0, 7'h02, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midslot.an_before", 8'(an), 8'h0D);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        check_reset_outputs("async_reset_hold");

        adjust  = 1'b1;
        select  = 1'b1;
        reset_n = 1'b1;
        check_frame("blk_sec_f0", ZEROS, 4'b0000);
        check_frame("blk_sec_f1", C236,  4'b0000);
        check_frame("blk_sec_f2", C236,  4'b0011);
        check_frame("blk_sec_f3", C236,  4'b0011);
        check_frame("blk_sec_f4", C236,  4'b0000);
        check_frame("blk_sec_f5", C236,  4'b0000);
        select = 1'b0;
        check_frame("blk_min_f6", C236,  4'b1100);
        check_slot("blk_min_f7.s0", 0, 7'h02, 1'b0);
        check_slot("blk_min_f7.s1", 1, 7'h30, 1'b0);
        check_slot("blk_min_f7.s2", 2, 7'h24, 1'b1);
        adjust = 1'b0;
        check_slot("exit_f7.s3", 3, 7'h3F, 1'b0);
        check_frame("exit_f8", C236, 4'b0000);
        adjust = 1'b1;
        check_frame("reenter_f9",  C236, 4'b0000);
        check_frame("reenter_f10", C236, 4'b0000);
        check_frame("reenter_f11", C236, 4'b1100);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
